// File: rtl/burst_seq_pkg.sv
// burst_seq_pkg: shared FSM state type, generator period codes and the
// cfg_data field layout used by burst_seq_ctrl and its sub-module.
package burst_seq_pkg;

  // Scheduler states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SETTLE,
    ST_RUN,
    ST_NEXT,
    ST_FINISH
  } state_e;

  // Burst generator period codes; P_OFF parks the generator.
  typedef enum logic [2:0] {
    P_OFF   = 3'd0,
    P_CODE1 = 3'd1,
    P_CODE2 = 3'd2,
    P_CODE3 = 3'd3,
    P_CODE4 = 3'd4,
    P_CODE5 = 3'd5,
    P_CODE6 = 3'd6,
    P_TEST  = 3'd7
  } period_e;

  // cfg_data layout, relative to the burst count width:
  //   [cnt_w-1:0]       burst count
  //   [cnt_w+2:cnt_w]   period code
  //   [cnt_w+3]         slot enable
  localparam int CFG_CODE_OFS = 0;
  localparam int CFG_EN_OFS   = 3;

  function automatic int cfg_code_lsb(input int cnt_w);
    return cnt_w + CFG_CODE_OFS;
  endfunction

  function automatic int cfg_en_pos(input int cnt_w);
    return cnt_w + CFG_EN_OFS;
  endfunction

endpackage

// File: rtl/burst_edge_wdog.sv
// burst_edge_wdog: rising-edge detector on the generator sync, per-channel
// edge counter and stall watchdog. Counters are held at zero outside RUN so
// every channel starts with a clean count and a fresh timeout window.
module burst_edge_wdog
  import burst_seq_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic             clk_100,
  input  logic             reset_n,
  input  logic             syn_i,
  input  logic             run_i,
  input  logic [CNT_W-1:0] target_i,
  output logic             edge_o,
  output logic             count_hit_o,
  output logic             timeout_o
);

  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic             syn_d_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;

  assign edge_o = syn_i & ~syn_d_q;

  // Final edge of the channel: the edge that brings the count to target.
  assign count_hit_o = run_i & edge_o & ((cnt_q + CNT_W'(1)) == target_i);

  // Raw watchdog expiry; the caller lets a coincident edge win.
  assign timeout_o = run_i & (wdog_q == WD_W'(TIMEOUT_CYC - 1));

  // Next edge count and watchdog value.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    cnt_d  = cnt_q;
    wdog_d = wdog_q;
    if (!run_i) begin
      cnt_d  = '0;
      wdog_d = '0;
    end else if (edge_o) begin
      cnt_d  = cnt_q + CNT_W'(1);
      wdog_d = '0;
    end else begin
      wdog_d = wdog_q + WD_W'(1);
    end
  end

  // Sync delay flop plus counter registers.
  always_ff @(posedge clk_100 or negedge reset_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      syn_d_q <= 1'b0;
      cnt_q   <= '0;
      wdog_q  <= '0;
    end else begin
      syn_d_q <= syn_i;
      cnt_q   <= cnt_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule

// File: rtl/burst_seq_ctrl.sv
// burst_seq_ctrl: scheduler in front of the burst sync generator. Walks the
// enabled channel slots, parks the generator during a settle gap after each
// mux switch, runs the slot's period code for its burst count and skips a
// channel whose generator stalls.
// Build option: define BURST_SEQ_LOOP_EN to repeat the slot list until stop.
module burst_seq_ctrl
  import burst_seq_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int SETTLE_CYC  = 100000,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic             clk_100,
  input  logic             reset_n,
  input  logic             cfg_wr,
  input  logic [2:0]       cfg_addr,
  input  logic [CNT_W+3:0] cfg_data,
  input  logic             start,
  input  logic             stop,
  input  logic             burst_syn,
  output logic [2:0]       burst_period,
  output logic [2:0]       chan_sel,
  output logic             busy,
  output logic             done,
  output logic             seq_err,
  output logic             cfg_rej
);

  localparam int         EN_POS   = cfg_en_pos(CNT_W);
  localparam int         CODE_LSB = cfg_code_lsb(CNT_W);
  localparam int         ST_W     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [2:0] LAST_IDX = 3'(NUM_CH - 1);

  // Channel slot table.
  logic [NUM_CH-1:0] slot_en_q;
  period_e           slot_code_q [NUM_CH];
  logic [CNT_W-1:0]  slot_cnt_q  [NUM_CH];

  // Scheduler registers.
  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] chan_sel_q, chan_sel_d;
  period_e    period_q, period_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       seq_err_q, seq_err_d;
  logic       cfg_rej_q, cfg_rej_d;
  logic [ST_W-1:0] settle_q, settle_d;
`ifdef BURST_SEQ_LOOP_EN
  logic       pass_hit_q, pass_hit_d;
`endif

  // Selected slot fields and edge/watchdog status.
  logic             sel_en;
  period_e          sel_code;
  logic [CNT_W-1:0] sel_cnt;
  logic             sel_elig;
  logic             syn_edge, count_hit, wdog_expired;

  // Slot table writes, accepted only while idle.
  always_ff @(posedge clk_100 or negedge reset_n) begin
    // NOTE: the slot table is small and must read as disabled after reset,
    // so it is reset like any other register rather than left as RAM.
    if (!reset_n) begin
      slot_en_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        slot_code_q[i] <= P_OFF;
        slot_cnt_q[i]  <= '0;
      end
    end else if (cfg_wr && state_q == ST_IDLE) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_addr == 3'(i)) begin
          slot_en_q[i]   <= cfg_data[EN_POS];
          slot_code_q[i] <= period_e'(cfg_data[CODE_LSB +: 3]);
          slot_cnt_q[i]  <= cfg_data[CNT_W-1:0];
        end
      end
    end
  end

  // Read mux for the slot addressed by idx_q.
  always_comb begin
    sel_en   = 1'b0;
    sel_code = P_OFF;
    sel_cnt  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx_q == 3'(i)) begin
        sel_en   = slot_en_q[i];
        sel_code = slot_code_q[i];
        sel_cnt  = slot_cnt_q[i];
      end
    end
  end

  assign sel_elig = sel_en && (sel_code != P_OFF) && (sel_cnt != '0);

  burst_edge_wdog #(
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_edge_wdog (
    .clk_100     (clk_100),
    .reset_n     (reset_n),
    .syn_i       (burst_syn),
    .run_i       (state_q == ST_RUN),
    .target_i    (sel_cnt),
    .edge_o      (syn_edge),
    .count_hit_o (count_hit),
    .timeout_o   (wdog_expired)
  );

  // Next-state and registered-output logic of the scheduler.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    chan_sel_d = chan_sel_q;
    period_d   = period_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    seq_err_d  = 1'b0;
    settle_d   = settle_q;
    cfg_rej_d  = cfg_wr && (state_q != ST_IDLE);
`ifdef BURST_SEQ_LOOP_EN
    pass_hit_d = pass_hit_q;
`endif

    if (stop && state_q != ST_IDLE) begin
      state_d  = ST_IDLE;
      period_d = P_OFF;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          period_d = P_OFF;
          if (start && !stop) begin
            state_d = ST_SELECT;
            idx_d   = '0;
            busy_d  = 1'b1;
`ifdef BURST_SEQ_LOOP_EN
            pass_hit_d = 1'b0;
`endif
          end
        end

        ST_SELECT: begin
          if (sel_elig) begin
            chan_sel_d = idx_q;
            settle_d   = '0;
            state_d    = ST_SETTLE;
`ifdef BURST_SEQ_LOOP_EN
            pass_hit_d = 1'b1;
`endif
          end else if (idx_q == LAST_IDX) begin
`ifdef BURST_SEQ_LOOP_EN
            if (pass_hit_q) begin
              done_d     = 1'b1;
              idx_d      = '0;
              pass_hit_d = 1'b0;
            end else begin
              state_d = ST_FINISH;
            end
`else
            state_d = ST_FINISH;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end

        ST_SETTLE: begin
          period_d = P_OFF;
          if (settle_q == ST_W'(SETTLE_CYC - 1)) begin
            period_d = sel_code;
            state_d  = ST_RUN;
          end else begin
            settle_d = settle_q + ST_W'(1);
          end
        end

        ST_RUN: begin
          // A final edge coinciding with expiry counts as a normal finish.
          if (count_hit) begin
            period_d = P_OFF;
            state_d  = ST_NEXT;
          end else if (wdog_expired && !syn_edge) begin
            seq_err_d = 1'b1;
            period_d  = P_OFF;
            state_d   = ST_NEXT;
          end
        end

        ST_NEXT: begin
          if (idx_q == LAST_IDX) begin
`ifdef BURST_SEQ_LOOP_EN
            if (pass_hit_q) begin
              done_d     = 1'b1;
              idx_d      = '0;
              pass_hit_d = 1'b0;
              state_d    = ST_SELECT;
            end else begin
              state_d = ST_FINISH;
            end
`else
            state_d = ST_FINISH;
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_SELECT;
          end
        end

        ST_FINISH: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end

        default: begin
          period_d = P_OFF;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      chan_sel_q <= '0;
      period_q   <= P_OFF;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      seq_err_q  <= 1'b0;
      cfg_rej_q  <= 1'b0;
      settle_q   <= '0;
`ifdef BURST_SEQ_LOOP_EN
      pass_hit_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      chan_sel_q <= chan_sel_d;
      period_q   <= period_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      seq_err_q  <= seq_err_d;
      cfg_rej_q  <= cfg_rej_d;
      settle_q   <= settle_d;
`ifdef BURST_SEQ_LOOP_EN
      pass_hit_q <= pass_hit_d;
`endif
    end
  end

  assign burst_period = period_q;
  assign chan_sel     = chan_sel_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign seq_err      = seq_err_q;
  assign cfg_rej      = cfg_rej_q;

endmodule

// File: tb/tb_burst_seq_ctrl.sv
// tb_burst_seq_ctrl: randomized self-checking bench for burst_seq_ctrl.
// Short settle/timeout values keep runs small; expectations come from a
// slot-table model and the scheduling rules, not from the DUT.
module tb_burst_seq_ctrl;

  localparam int NUM_CH      = 4;
  localparam int CNT_W       = 16;
  localparam int SETTLE_CYC  = 20;
  localparam int TIMEOUT_CYC = 60;
  localparam int DW          = CNT_W + 4;

  logic          clk_100 = 1'b0;
  logic          reset_n;
  logic          cfg_wr;
  logic [2:0]    cfg_addr;
  logic [DW-1:0] cfg_data;
  logic          start, stop, burst_syn;
  logic [2:0]    burst_period, chan_sel;
  logic          busy, done, seq_err, cfg_rej;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference slot table.
  bit m_en   [NUM_CH];
  int m_code [NUM_CH];
  int m_cnt  [NUM_CH];

  burst_seq_ctrl #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .SETTLE_CYC  (SETTLE_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_100      (clk_100),
    .reset_n      (reset_n),
    .cfg_wr       (cfg_wr),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .start        (start),
    .stop         (stop),
    .burst_syn    (burst_syn),
    .burst_period (burst_period),
    .chan_sel     (chan_sel),
    .busy         (busy),
    .done         (done),
    .seq_err      (seq_err),
    .cfg_rej      (cfg_rej)
  );

  always #5 clk_100 = ~clk_100;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are read 1 ns after the edge.
  task automatic tick();
    @(posedge clk_100);
    #1;
    cyc++;
  endtask

  function automatic bit eligible(input int i);
    return m_en[i] && (m_code[i] != 0) && (m_cnt[i] != 0);
  endfunction

  task automatic write_slot(input int addr, input bit en, input int code, input int cnt);
    cfg_wr   = 1'b1;
    cfg_addr = 3'(addr);
    cfg_data = {en, 3'(code), CNT_W'(cnt)};
    tick();
    cfg_wr = 1'b0;
    check("cfg_rej_idle", cfg_rej, 0);
    if (addr < NUM_CH) begin
      m_en[addr]   = en;
      m_code[addr] = code & 7;
      m_cnt[addr]  = cnt & ((1 << CNT_W) - 1);
    end
  endtask

  // One single-pass sequence. Timing rules used: one cycle per slot scanned,
  // one NEXT cycle, SETTLE_CYC idle cycles, one FINISH cycle, registered outputs.
  task automatic run_pass(input int stall_slot, input int stop_slot, input bit rej_write);
    int exp_q[$];
    int last_j, ref_c, want, edges, k, hi_left, lo_left, bound;
    bit prev;
    for (int i = 0; i < NUM_CH; i++) if (eligible(i)) exp_q.push_back(i);

    start = 1'b1;
    tick();
    start = 1'b0;
    ref_c  = cyc - 1;
    last_j = -1;
    check("busy_after_start", busy, 1);

    if (rej_write) begin
      cfg_wr   = 1'b1;
      cfg_addr = 3'($urandom_range(0, NUM_CH - 1));
      cfg_data = DW'($urandom);
      tick();
      cfg_wr = 1'b0;
      check("cfg_rej_busy", cfg_rej, 1);
      tick();
      check("cfg_rej_width", cfg_rej, 0);
    end

    for (int n = 0; n < exp_q.size(); n++) begin
      k    = exp_q[n];
      want = k - last_j + 1 + SETTLE_CYC;
      while (burst_period == 3'd0 && (cyc - ref_c) < want + 4) tick();
      check("settle_gap", cyc - ref_c, want);
      check("run_chan_sel", chan_sel, k);
      check("run_period", burst_period, m_code[k]);
      ref_c = cyc;

      if (k == stop_slot) begin
        repeat (10) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_period_off", burst_period, 0);
        check("stop_busy_low", busy, 0);
        for (int c = 0; c < NUM_CH + 4; c++) begin
          tick();
          check("stop_no_done", done, 0);
        end
        return;
      end

      if (k == stall_slot) begin
        burst_syn = 1'b0;
        while (seq_err !== 1'b1 && (cyc - ref_c) < TIMEOUT_CYC + 4) tick();
        check("wdog_delay", cyc - ref_c, TIMEOUT_CYC);
        check("wdog_period_off", burst_period, 0);
        ref_c = cyc;
        tick();
        check("seq_err_width", seq_err, 0);
      end else begin
        edges   = 0;
        prev    = 1'b0;
        hi_left = 0;
        lo_left = $urandom_range(0, 3);
        bound   = m_cnt[k] * 8 + 8;
        while (edges < m_cnt[k] && (cyc - ref_c) < bound) begin
          if (hi_left > 0) begin
            burst_syn = 1'b1;
            hi_left--;
          end else if (lo_left > 0) begin
            burst_syn = 1'b0;
            lo_left--;
          end else begin
            burst_syn = 1'b1;
            hi_left   = $urandom_range(0, 2);
            lo_left   = $urandom_range(1, 4);
          end
          if (burst_syn && !prev) edges++;
          prev = burst_syn;
          tick();
          check("run_period_track", burst_period, (edges == m_cnt[k]) ? 0 : m_code[k]);
          check("run_no_seq_err", seq_err, 0);
        end
        burst_syn = 1'b0;
        ref_c     = cyc;
      end
      last_j = k;
    end

    want = NUM_CH - last_j + 1;
    while (done !== 1'b1 && (cyc - ref_c) < want + 4) tick();
    check("done_delay", cyc - ref_c, want);
    check("done_busy_low", busy, 0);
    check("done_period_off", burst_period, 0);
    if (last_j >= 0) check("chan_sel_hold", chan_sel, last_j);
    tick();
    check("done_width", done, 0);
  endtask

`ifdef BURST_SEQ_LOOP_EN
  task automatic loop_test();
    int ref_c, seen_done;
    write_slot(0, 1'b1, 2, 1);
    for (int i = 1; i < NUM_CH; i++) write_slot(i, 1'b0, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 0; p < 4; p++) begin
      ref_c     = cyc;
      seen_done = 0;
      while (burst_period == 3'd0 && (cyc - ref_c) < NUM_CH + SETTLE_CYC + 8) begin
        tick();
        if (done === 1'b1) begin
          seen_done++;
          check("loop_busy_at_done", busy, 1);
        end
      end
      if (p > 0) check("loop_done_per_wrap", seen_done, 1);
      check("loop_period", burst_period, 2);
      check("loop_chan_sel", chan_sel, 0);
      if (p == 3) break;
      burst_syn = 1'b1;
      tick();
      burst_syn = 1'b0;
      check("loop_period_off", burst_period, 0);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("loop_stop_busy", busy, 0);
    check("loop_stop_period", burst_period, 0);
    for (int c = 0; c < NUM_CH + 4; c++) begin
      tick();
      check("loop_stop_no_done", done, 0);
    end
  endtask
`endif

  initial begin
    int stall;
    reset_n   = 1'b0;
    cfg_wr    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    start     = 1'b0;
    stop      = 1'b0;
    burst_syn = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_en[i]   = 1'b0;
      m_code[i] = 0;
      m_cnt[i]  = 0;
    end
    repeat (3) tick();
    check("rst_burst_period", burst_period, 0);
    check("rst_chan_sel", chan_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_seq_err", seq_err, 0);
    check("rst_cfg_rej", cfg_rej, 0);
    reset_n = 1'b1;
    tick();

    // start together with stop in IDLE is ignored.
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_ignored", busy, 0);
    tick();
    check("start_stop_idle", busy, 0);

    // Cleared slots: done after NUM_CH+2 cycles.
    run_pass(-1, -1, 1'b0);

`ifdef BURST_SEQ_LOOP_EN
    loop_test();
`else
    // Single slot.
    write_slot(0, 1'b1, 3, 5);
    run_pass(-1, -1, 1'b0);

    // Slot 1 has code 0 and is skipped; writes past NUM_CH are ignored.
    write_slot(0, 1'b1, 4, 2);
    write_slot(1, 1'b1, 0, 7);
    write_slot(2, 1'b1, 6, 3);
    write_slot(NUM_CH, 1'b1, 5, 1);
    run_pass(-1, -1, 1'b0);

    // Stalled generator on slot 0.
    write_slot(0, 1'b1, 3, 5);
    write_slot(2, 1'b0, 6, 3);
    run_pass(0, -1, 1'b0);

    // Abort during RUN, then a fresh pass from slot 0.
    write_slot(2, 1'b1, 7, 2);
    run_pass(-1, 0, 1'b0);
    run_pass(-1, -1, 1'b0);

    // Rejected write while busy leaves the table untouched.
    run_pass(-1, -1, 1'b1);
    run_pass(-1, -1, 1'b0);

    // Random tables.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < NUM_CH; i++)
        write_slot(i, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 4));
      write_slot($urandom_range(NUM_CH, 7), 1'b1, $urandom_range(1, 7), $urandom_range(1, 4));
      stall = ($urandom_range(0, 2) == 0) ? $urandom_range(0, NUM_CH - 1) : -1;
      run_pass(stall, -1, 1'($urandom_range(0, 1)));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
